// File: rtl/instr_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage_if
// Purpose  : Load/fetch control and IF/ID bus for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
interface instr_fetch_stage_if #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
);
    logic          LoadInstructions;
    logic [31:0]   Instruction;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   if_id_instr;
    logic [31:0]   if_id_pc;
    logic          if_id_valid;
    logic [31:0]   pc;
    logic [AW:0]   load_count;
    logic          mem_full;

    modport master (
        output LoadInstructions, Instruction, stall, redirect, redirect_pc,
        input  if_id_instr, if_id_pc, if_id_valid, pc, load_count, mem_full
    );

    modport slave (
        input  LoadInstructions, Instruction, stall, redirect, redirect_pc,
        output if_id_instr, if_id_pc, if_id_valid, pc, load_count, mem_full
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage
// Purpose  : Instruction memory, program counter and IF/ID register.
// Revision : 1.0
// ============================================================================
module instr_fetch_stage #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic                  clk,
    input  logic                  Reset,
    instr_fetch_stage_if.slave    bus
);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_pc;
    logic [31:0]   r_if_instr;
    logic [31:0]   r_if_pc;
    logic          r_if_valid;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_load_count;
    logic          r_load_active;

    logic          w_session_start;
    logic          w_full;
    logic          w_write_en;
    logic [AW-1:0] w_write_addr;
    logic [AW-1:0] w_word;
    logic          w_in_range;
    logic [31:0]   w_pc_plus4;

    // A session starts on the first load cycle after fetch mode or reset.
    assign w_session_start = !r_load_active;
    assign w_full          = (r_load_count == c_DEPTH);
    assign w_write_en      = bus.LoadInstructions && (w_session_start || !w_full);
    assign w_write_addr    = w_session_start ? '0 : r_wr_ptr;

    // Upper PC bits must be zero so targets past DEPTH words never alias.
    assign w_word     = r_pc[AW+1:2];
    assign w_in_range = (r_pc[31:AW+2] == '0) && ({1'b0, w_word} < r_load_count);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (Reset && w_write_en) begin
            r_mem[w_write_addr] <= bus.Instruction;
        end
    end

    // load_count is deliberately outside the reset so a program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_pc          <= '0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_valid    <= 1'b0;
            r_wr_ptr      <= '0;
            r_load_active <= 1'b0;
        end else if (bus.LoadInstructions) begin
            r_load_active <= 1'b1;
            r_pc          <= '0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_valid    <= 1'b0;
            if (w_session_start) begin
                r_wr_ptr     <= AW'(1);
                r_load_count <= (AW+1)'(1);
            end else if (!w_full) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_load_count <= r_load_count + (AW+1)'(1);
            end
        end else begin
            r_load_active <= 1'b0;
            if (bus.redirect) begin
                r_pc       <= bus.redirect_pc & ~32'h3;
                r_if_instr <= '0;
                r_if_valid <= 1'b0;
            end else if (!bus.stall) begin
                r_if_pc <= w_pc_plus4;
                if (w_in_range) begin
                    r_if_instr <= r_mem[w_word];
                    r_if_valid <= 1'b1;
                    r_pc       <= w_pc_plus4;
                end else begin
                    r_if_instr <= '0;
                    r_if_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.if_id_instr = r_if_instr;
    assign bus.if_id_pc    = r_if_pc;
    assign bus.if_id_valid = r_if_valid;
    assign bus.pc          = r_pc;
    assign bus.load_count  = r_load_count;
    assign bus.mem_full    = w_full;

endmodule
`default_nettype wire

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch front end of the pipelined CPU: owns the instruction memory, the program counter and the IF/ID pipeline register. While `LoadInstructions` is high it serially writes `Instruction` words into instruction memory. Otherwise it fetches one word per clock into IF/ID, which feeds the decode stage. It accepts `stall` from the hazard-detection unit and `redirect` from the branch/jump logic.

## Interface
- `DEPTH`, 32: instruction memory size in 32-bit words; must be a power of two.
- `AW`, 5: word-address width; must equal log2(`DEPTH`).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-low reset; takes priority over all other inputs.
- `LoadInstructions`  in  1  1 = load mode, 0 = fetch mode.
- `Instruction`  in  32  word to write in load mode.
- `stall`  in  1  hold PC and IF/ID (load-use hazard).
- `redirect`  in  1  take branch/jump; overrides `stall`.
- `redirect_pc`  in  32  byte target; bits [1:0] ignored.
- `if_id_instr`  out  32  IF/ID instruction; 0 (NOP) when invalid.
- `if_id_pc`  out  32  IF/ID PC+4 of the fetched word.
- `if_id_valid`  out  1  IF/ID holds a real fetched word.
- `pc`  out  32  current fetch PC (byte address).
- `load_count`  out  AW+1  program length in words.
- `mem_full`  out  1  `load_count` == `DEPTH`.

## Operation
- **Reset (`Reset`=0 at the edge):**
  - `pc`=0, `if_id_instr`=0, `if_id_pc`=0, `if_id_valid`=0, write pointer=0.
  - Memory contents and `load_count` are NOT cleared. A reset pulse between load and run must preserve the program.
- **Load mode (`Reset`=1, `LoadInstructions`=1):**
  - Rising edge of the mode (previous cycle `LoadInstructions`=0, or first cycle after reset) starts a session: word is written at address 0, `load_count`=1.
  - Each subsequent cycle writes `mem[wr_ptr]`, then `wr_ptr`++ and `load_count`++.
  - When `load_count`==`DEPTH`, further words are discarded and `mem_full`=1. No wrap-around.
  - During load: `pc` is held at 0, IF/ID is forced to NOP with `valid`=0, and `stall`/`redirect` are ignored.
- **Fetch mode (`Reset`=1, `LoadInstructions`=0):** word address w = `pc`[AW+1:2]. Memory read is combinational. Priority:
  1. `redirect`=1 → `pc` ← {`redirect_pc`[31:2], 2'b00}; IF/ID ← NOP, `valid`=0. This applies even if `stall`=1.
  2. `stall`=1 → `pc` and all IF/ID outputs hold.
  3. Otherwise, if w < `load_count`: IF/ID ← `mem[w]`, `if_id_pc` ← `pc`+4, `valid`=1, `pc` ← `pc`+4.
  4. Otherwise (w ≥ `load_count`, end of program): IF/ID ← NOP, `valid`=0, `if_id_pc` ← `pc`+4, and `pc` holds. `pc` never wraps.
- Redirect target beyond `load_count` is legal and fetches NOPs. Targets beyond `DEPTH` words behave the same.
- Old words above a shorter reloaded program remain in memory but are never fetched, because fetch is gated by `load_count`.

## Timing
- Fetch latency is 1 cycle: the word at `pc`=4k appears on `if_id_instr` after the next rising edge.
- First edge after reset release in fetch mode captures `mem[0]`. Thereafter one word is fetched per cycle.
- `stall` held for N cycles holds IF/ID for exactly N extra cycles.
- After `redirect`, there is one NOP bubble, then `mem[target/4]` on the following edge.
- Load throughput is one word per cycle. `load_count`/`mem_full` update on the same edge as the write.
- Load→fetch transition: the first fetch-mode edge uses `pc`=0 and captures `mem[0]`.

## Test plan
- **Program load and run:**
  - Stimulus: load 12 words (0x00000000, 0x200101A7 addi R1,423, 0x2002005C, 0x2003000D, 0x20040092, 0x20050005, 0x00242820, 0x0065302A, 0x8C040004, 0x00863822, 0xAC070002, 0x00E24020), pulse `Reset`, then run.
  - Expected: `load_count`=12; `if_id_instr` steps through the 12 words with `valid`=1 and `if_id_pc`=4,8,…,48; then NOP with `valid`=0 and `pc` stuck at 48.
- **Stall:**
  - Stimulus: assert `stall` for 2 cycles while IF/ID holds word 3 (0x2003000D).
  - Expected: 0x2003000D held for 2 extra cycles, `pc`=16 held; next edge captures word 4.
- **Redirect over stall:**
  - Stimulus: `redirect`=1, `redirect_pc`=0x0000000B, `stall`=1.
  - Expected: `pc`=0x8, IF/ID NOP with `valid`=0; the following edge captures 0x2002005C with `if_id_pc`=0xC.
- **Overflow:**
  - Stimulus: load 34 words with `DEPTH`=32.
  - Expected: `load_count`=32, `mem_full`=1; words 33–34 are dropped and word 0 is intact.
- **Reset mid-fetch:**
  - Stimulus: `Reset`=0 for one edge while `pc`=0x14.
  - Expected: `pc`=0 and IF/ID cleared; `load_count` is unchanged; after release, `mem[0]` is re-fetched.
- **Reload shorter program:**
  - Stimulus: a second load session of 3 words.
  - Expected: `load_count`=3; fetch at `pc`=12 yields NOP with `valid`=0 despite the old word 3 remaining in memory.
